pipe_slip_encoder: RTL and testbench

PIPE_SLIP_ENCODER -- requirements
Module: pipe_slip_encoder

---
 rtl/slip_pkg.sv | 27 ++
 rtl/pipe_slip_out_reg.sv | 44 ++++
 rtl/pipe_slip_encoder.sv | 142 ++++++++++++++
 tb/tb_pipe_slip_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/slip_pkg.sv
// rtl/slip_pkg.sv - shared SLIP constants, encoder states and helpers (S_LEAD present only with SLIP_LEAD_END_EN)
package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        S_PASS = 2'd0,
        S_ESC2 = 2'd1,
`ifdef SLIP_LEAD_END_EN
        S_TAIL = 2'd2,
        S_LEAD = 2'd3
`else
        S_TAIL = 2'd2
`endif
    } slip_state_e;

    // A byte needs the two-byte escaped form when it collides with END or ESC.
    function automatic logic slip_is_special(input logic [7:0] b,
                                             input logic [7:0] end_c,
                                             input logic [7:0] esc_c);
        return (b == end_c) || (b == esc_c);
    endfunction

endpackage

// File: rtl/pipe_slip_out_reg.sv
// rtl/pipe_slip_out_reg.sv - single output register stage with hold while stalled
module pipe_slip_out_reg (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       out_ready_i,
    output logic       adv_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    // The stage may take a new byte when empty or when its byte leaves this cycle.
    assign adv_o       = !valid_q || out_ready_i;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

    // Next-state: hold everything while stalled; otherwise load or go empty.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (adv_o) begin
            valid_d = load_i;
            if (load_i) begin
                data_d = load_data_i;
            end
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pipe_slip_encoder.sv
// rtl/pipe_slip_encoder.sv - SLIP frame encoder, optional leading END under SLIP_LEAD_END_EN
module pipe_slip_encoder
    import slip_pkg::*;
#(
    parameter logic [7:0] END_CHAR = SLIP_END,
    parameter logic [7:0] ESC_CHAR = SLIP_ESC,
    parameter logic [7:0] ESC_END  = SLIP_ESC_END,
    parameter logic [7:0] ESC_ESC  = SLIP_ESC_ESC
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_start,
    input  logic        in_stop,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pkt_count
);

    slip_state_e state_q, state_d;
    logic [7:0]  held_q, held_d;
    logic        stop_q, stop_d;
    logic        tail_q, tail_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        adv;
    logic        load;
    logic [7:0]  load_data;
    logic        accept;

`ifndef SLIP_LEAD_END_EN
    logic unused_start;
    assign unused_start = in_start;
`endif

    assign in_ready  = reset && (state_q == S_PASS) && adv;
    assign accept    = in_valid && in_ready;
    assign pkt_count = pkt_count_q;

    pipe_slip_out_reg u_out_reg (
        .clk_i       (clk_48mhz),
        .resetn_i    (reset),
        .load_i      (load),
        .load_data_i (load_data),
        .out_ready_i (out_ready),
        .adv_o       (adv),
        .out_data_o  (out_data),
        .out_valid_o (out_valid)
    );

    // Next-state: pick the byte to load into the output stage and the follow-on state.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        stop_d      = stop_q;
        tail_d      = tail_q;
        load        = 1'b0;
        load_data   = 8'h00;
        pkt_count_d = pkt_count_q;

        if (out_valid && out_ready && tail_q) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
        if (adv) begin
            tail_d = (state_q == S_TAIL);
        end

        case (state_q)
            S_PASS: begin
                if (accept) begin
                    held_d = in_data;
                    stop_d = in_stop;
                    load   = 1'b1;
`ifdef SLIP_LEAD_END_EN
                    if (in_start) begin
                        load_data = END_CHAR;
                        state_d   = S_LEAD;
                    end else
`endif
                    if (slip_is_special(in_data, END_CHAR, ESC_CHAR)) begin
                        load_data = ESC_CHAR;
                        state_d   = S_ESC2;
                    end else begin
                        load_data = in_data;
                        state_d   = in_stop ? S_TAIL : S_PASS;
                    end
                end
            end
`ifdef SLIP_LEAD_END_EN
            S_LEAD: begin
                if (adv) begin
                    load = 1'b1;
                    if (slip_is_special(held_q, END_CHAR, ESC_CHAR)) begin
                        load_data = ESC_CHAR;
                        state_d   = S_ESC2;
                    end else begin
                        load_data = held_q;
                        state_d   = stop_q ? S_TAIL : S_PASS;
                    end
                end
            end
`endif
            S_ESC2: begin
                if (adv) begin
                    load      = 1'b1;
                    load_data = (held_q == END_CHAR) ? ESC_END : ESC_ESC;
                    state_d   = stop_q ? S_TAIL : S_PASS;
                end
            end
            S_TAIL: begin
                if (adv) begin
                    load      = 1'b1;
                    load_data = END_CHAR;
                    state_d   = S_PASS;
                end
            end
            default: begin
                state_d = S_PASS;
            end
        endcase
    end

    // State, held byte/flags and packet counter; reset drops any pending escape or tail.
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            state_q     <= S_PASS;
            held_q      <= 8'h00;
            stop_q      <= 1'b0;
            tail_q      <= 1'b0;
            pkt_count_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            stop_q      <= stop_d;
            tail_q      <= tail_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_slip_encoder.sv
// tb/tb_pipe_slip_encoder.sv - scoreboard bench for pipe_slip_encoder
module tb_pipe_slip_encoder;

    logic        clk_48mhz = 1'b0;
    logic        reset     = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_start  = 1'b0;
    logic        in_stop   = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    pipe_slip_encoder dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .in_data   (in_data),
        .in_start  (in_start),
        .in_stop   (in_stop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: every output transfer pops one expected byte.
    always @(negedge clk_48mhz) begin
        logic [7:0] e;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_byte: got %02h want none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_byte", 32'(out_data), 32'(e));
            end
        end
    end

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic push_lead();
`ifdef SLIP_LEAD_END_EN
        exp_q.push_back(8'hC0);
`endif
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic st, input logic sp, output int waits);
        logic seen;
        in_data  = d;
        in_start = st;
        in_stop  = sp;
        in_valid = 1'b1;
        waits    = 0;
        seen     = 1'b0;
        while (!seen && waits < 50) begin
            @(negedge clk_48mhz);
            if (in_ready) seen = 1'b1;
            else waits++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
        end
        @(posedge clk_48mhz);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_stop  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_48mhz);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        repeat (3) @(posedge clk_48mhz);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int w;
        // Reset state
        @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clk_48mhz);
        #1;
        reset = 1'b1;

        // 41,42 -> 41,42,C0
        push_lead(); push(8'h41); push(8'h42); push(8'hC0);
        send(8'h41, 1'b1, 1'b0, w);
        send(8'h42, 1'b0, 1'b1, w);
        drain();
        chk("pkt_after_41_42", 32'(pkt_count), 32'd1);

        // Single C0 with start&stop -> DB,DC,C0
        push_lead(); push(8'hDB); push(8'hDC); push(8'hC0);
        send(8'hC0, 1'b1, 1'b1, w);
        drain();
        chk("pkt_after_c0", 32'(pkt_count), 32'd2);

        // DB mid-packet -> DB,DD with in_ready low for one cycle
        push_lead(); push(8'h01);
        send(8'h01, 1'b1, 1'b0, w);
        drain();
        push(8'hDB); push(8'hDD);
        send(8'hDB, 1'b0, 1'b0, w);
        chk("esc_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk_48mhz);
        #1;
        chk("esc_in_ready_back", 32'(in_ready), 32'd1);
        push(8'h02); push(8'hC0);
        send(8'h02, 1'b0, 1'b1, w);
        drain();
        chk("pkt_after_db", 32'(pkt_count), 32'd3);

        // 10..13 back-to-back: one per cycle, one cycle latency
        for (int i = 0; i < 4; i++) begin
            push(8'h10 + 8'(i));
            in_data  = 8'h10 + 8'(i);
            in_valid = 1'b1;
            @(negedge clk_48mhz);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_out_data", 32'(out_data), 32'h10 + 32'(i) - 32'd1);
            end
            @(posedge clk_48mhz);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk_48mhz);
        chk("stream_last_data", 32'(out_data), 32'h13);
        @(posedge clk_48mhz);
        #1;
        push(8'h14); push(8'hC0);
        send(8'h14, 1'b0, 1'b1, w);
        drain();
        chk("pkt_after_stream", 32'(pkt_count), 32'd4);

        // DB with stop, stall for 5 cycles
        push(8'hDB); push(8'hDD); push(8'hC0);
        send(8'hDB, 1'b0, 1'b1, w);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_48mhz);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'hDB);
        end
        @(posedge clk_48mhz);
        #1;
        out_ready = 1'b1;
        drain();
        chk("pkt_after_stall", 32'(pkt_count), 32'd5);

        // Reset while in S_ESC2 discards the pending DD
        send(8'hDB, 1'b0, 1'b0, w);
        reset = 1'b0;
        @(posedge clk_48mhz);
        #1;
        reset = 1'b1;
        @(negedge clk_48mhz);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clk_48mhz);
        #1;
        push_lead(); push(8'h55); push(8'hC0);
        send(8'h55, 1'b1, 1'b1, w);
        drain();
        chk("pkt_after_midrst", 32'(pkt_count), 32'd1);

        // Counter wrap: preload near the top, then finish two one-byte packets
        @(negedge clk_48mhz);
        force dut.pkt_count_q = 16'hFFFE;
        #1;
        release dut.pkt_count_q;
        @(posedge clk_48mhz);
        #1;
        chk("wrap_preload", 32'(pkt_count), 32'hFFFE);
        push_lead(); push(8'h20); push(8'hC0);
        send(8'h20, 1'b1, 1'b1, w);
        drain();
        chk("wrap_ffff", 32'(pkt_count), 32'hFFFF);
        push_lead(); push(8'h21); push(8'hC0);
        send(8'h21, 1'b1, 1'b1, w);
        drain();
        chk("wrap_zero", 32'(pkt_count), 32'h0000);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
